// File: rtl/enum_chan_seq.sv
// enum_chan_seq: per-channel FIRST/SECOND/DONE code sequencer with a shared, saturating completion counter
// Ports: clk, rst_n (async, active-low); start/abort/done_ack per channel;
//        code_o = state code of each channel (channel i at [i*WIDTH +: WIDTH]),
//        done_o per channel, busy_o = any channel active, done_cnt_o = acknowledged completions (saturating).
module enum_chan_seq #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int HOLD     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       done_ack,
  output logic [CHANNELS*WIDTH-1:0] code_o,
  output logic [CHANNELS-1:0]       done_o,
  output logic                      busy_o,
  output logic [7:0]                done_cnt_o
);
  // Shifting all-ones right by floor(WIDTH/2) leaves the low ceil(WIDTH/2) bits set.
  localparam logic [WIDTH-1:0] FIRST_C = {WIDTH{1'b1}} >> (WIDTH / 2);
  typedef enum logic [WIDTH-1:0] {
    IDLE   = {WIDTH{1'b0}},
    FIRST  = FIRST_C,
    SECOND = ~FIRST_C,
    DONE   = {WIDTH{1'b1}}
  } state_e;
  state_e     state_q [CHANNELS];
  state_e     state_d [CHANNELS];
  logic [7:0] cnt_q   [CHANNELS];
  logic [7:0] cnt_d   [CHANNELS];
  logic [7:0] done_cnt_q, done_cnt_d;
  logic [8:0] sum;
  always_comb begin
    sum = {1'b0, done_cnt_q};
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (abort[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            state_d[i] = start[i] ? FIRST : IDLE;
            cnt_d[i]   = '0;
          end
          FIRST: begin
            state_d[i] = (cnt_q[i] == 8'(HOLD - 1)) ? SECOND : FIRST;
            cnt_d[i]   = (cnt_q[i] == 8'(HOLD - 1)) ? 8'd0 : cnt_q[i] + 8'd1;
          end
          SECOND: begin
            state_d[i] = (cnt_q[i] == 8'(HOLD - 1)) ? DONE : SECOND;
            cnt_d[i]   = (cnt_q[i] == 8'(HOLD - 1)) ? 8'd0 : cnt_q[i] + 8'd1;
          end
          DONE: begin
            state_d[i] = done_ack[i] ? IDLE : DONE;
            sum        = done_ack[i] ? sum + 9'd1 : sum;
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
    done_cnt_d = (sum > 9'd255) ? 8'hff : sum[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      done_cnt_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      done_cnt_q <= done_cnt_d;
    end
  end
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      code_o[i*WIDTH +: WIDTH] = state_q[i];
      done_o[i]                = (state_q[i] == DONE);
      busy_o                   = busy_o | (state_q[i] != IDLE);
    end
  end
  assign done_cnt_o = done_cnt_q;
endmodule

// File: tb/tb_enum_chan_seq.sv
// tb_enum_chan_seq: scoreboard bench for enum_chan_seq against an age-based reference model
module tb_enum_chan_seq;
  localparam int W = 5, C = 4, H = 2;
  logic clk = 0, rst_n = 0;
  logic [C-1:0] start = '0, abort = '0, done_ack = '0;
  logic [C*W-1:0] code;
  logic [C-1:0] done;
  logic busy;
  logic [7:0] cnt;
  logic s1 = 0, a1 = 0, k1 = 0;
  logic [5:0] code1;
  logic done1, busy1;
  logic [7:0] cnt1;

  enum_chan_seq #(.WIDTH(W), .CHANNELS(C), .HOLD(H)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .done_ack(done_ack),
    .code_o(code), .done_o(done), .busy_o(busy), .done_cnt_o(cnt));
  enum_chan_seq #(.WIDTH(6), .CHANNELS(1), .HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .abort(a1), .done_ack(k1),
    .code_o(code1), .done_o(done1), .busy_o(busy1), .done_cnt_o(cnt1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [C*W-1:0] code;
    logic [C-1:0]   done;
    logic           busy;
    logic [7:0]     cnt;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int age[C];
  int mcnt;

  // age: -1 idle, otherwise cycles since the channel entered FIRST
  function automatic logic [W-1:0] code_of(int a);
    logic [W-1:0] f = '0;
    for (int b = 0; b < (W + 1) / 2; b++) f[b] = 1'b1;
    return a < 0 ? '0 : a < H ? f : a < 2 * H ? ~f : '1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) age[i] = -1;
    mcnt = 0;
    q.delete();
  endtask

  task automatic step(logic [C-1:0] s, logic [C-1:0] a, logic [C-1:0] k);
    exp_t e;
    @(negedge clk);
    start = s; abort = a; done_ack = k;
    for (int i = 0; i < C; i++) begin
      if (a[i]) age[i] = -1;
      else if (age[i] < 0) begin if (s[i]) age[i] = 0; end
      else if (age[i] < 2 * H) age[i]++;
      else if (k[i]) begin
        age[i] = -1;
        if (mcnt < 255) mcnt++;
      end
    end
    e.busy = 1'b0;
    for (int i = 0; i < C; i++) begin
      e.code[i*W +: W] = code_of(age[i]);
      e.done[i] = (age[i] >= 2 * H);
      e.busy = e.busy | (age[i] >= 0);
    end
    e.cnt = mcnt[7:0];
    q.push_back(e);
  endtask

  task automatic rand_step();
    logic [C-1:0] s, a, k;
    for (int i = 0; i < C; i++) begin
      s[i] = ($urandom_range(0, 99) < 30);
      a[i] = ($urandom_range(0, 99) < 4);
      k[i] = ($urandom_range(0, 99) < 40);
    end
    step(s, a, k);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("code_o", 32'(code), 32'(e.code));
      chk("done_o", 32'(done), 32'(e.done));
      chk("busy_o", 32'(busy), 32'(e.busy));
      chk("done_cnt_o", 32'(cnt), 32'(e.cnt));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_code", 32'(code), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt), 0);
    rst_n = 1;
    // single sequence on channel 0
    step(4'b0001, 0, 0);
    @(posedge clk); #2;
    chk("seq_first", 32'(code[4:0]), 32'h07);
    step(0, 0, 0); step(0, 0, 0);
    @(posedge clk); #2;
    chk("seq_second", 32'(code[4:0]), 32'h18);
    repeat (3) step(0, 0, 0);
    @(posedge clk); #2;
    chk("seq_done_code", 32'(code[4:0]), 32'h1f);
    chk("seq_done_flag", 32'(done[0]), 1);
    step(0, 0, 4'b0001);
    @(posedge clk); #2;
    chk("seq_ack_idle", 32'(code[4:0]), 0);
    chk("seq_ack_cnt", 32'(cnt), 1);
    // two channels acked in the same cycle
    step(4'b1001, 0, 0);
    repeat (5) step(0, 0, 0);
    step(0, 0, 4'b1001);
    @(posedge clk); #2;
    chk("dual_ack_cnt", 32'(cnt), 3);
    // abort during SECOND, then abort together with ack in DONE
    step(4'b0010, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 4'b0010, 0);
    @(posedge clk); #2;
    chk("abort_code", 32'(code[9:5]), 0);
    chk("abort_cnt", 32'(cnt), 3);
    step(4'b0010, 0, 0);
    repeat (4) step(0, 0, 0);
    step(0, 4'b0010, 4'b0010);
    @(posedge clk); #2;
    chk("abort_ack_cnt", 32'(cnt), 3);
    // saturation on channel 2
    for (int n = 0; n < 260; n++) begin
      step(4'b0100, 0, 0);
      repeat (4) step(0, 0, 0);
      step(0, 0, 4'b0100);
    end
    @(posedge clk); #2;
    chk("sat_cnt", 32'(cnt), 255);
    repeat (300) rand_step();
    // asynchronous reset mid-FIRST with start held through release
    step(4'b0001, 0, 0);
    @(posedge clk); #2;
    rst_n = 0;
    start = '1;
    #1;
    chk("async_code", 32'(code), 0);
    chk("async_done", 32'(done), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_cnt", 32'(cnt), 0);
    model_reset();
    @(posedge clk); #2;
    chk("rst_hold_code", 32'(code), 0);
    rst_n = 1;
    #1;
    chk("release_code", 32'(code), 0);
    step(4'b1111, 0, 0);
    repeat (1200) rand_step();
    // narrow variant: WIDTH=6, HOLD=1, one channel
    @(negedge clk); s1 = 1;
    @(posedge clk); #2; s1 = 0;
    chk("w6_first", 32'(code1), 32'h07);
    @(posedge clk); #2;
    chk("w6_second", 32'(code1), 32'h38);
    @(posedge clk); #2;
    chk("w6_done", 32'(code1), 32'h3f);
    chk("w6_done_flag", 32'(done1), 1);
    k1 = 1;
    @(posedge clk); #2; k1 = 0;
    chk("w6_idle", 32'(code1), 0);
    chk("w6_cnt", 32'(cnt1), 1);
    @(posedge clk); #3;
    chk("drain", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
